count_capture_fifo: RTL and testbench
=====================================

# count_capture_fifo

Event-capture stage downstream of the 4-bit synchronous counter. It synchronises an asynchronous event input and detects its rising edges. On each rising edge it samples the counter value and queues it in a small show-ahead FIFO. The FIFO is drained over a valid/ready interface, so software or a downstream stage can read event timestamps without missing events that occur close together.

## Interface
- CNT_W, 4, width of count_in and out_data
- DEPTH, 4, FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops on event_in; ≥2
- clk  input  1  clock, all logic rising-edge
- reset  input  1  asynchronous, active-high reset
- count_in  input  CNT_W  free-running counter value, synchronous to clk
- event_in  input  1  asynchronous event; rising edge triggers capture
- clr_ovf  input  1  one-cycle pulse, clears overflow
- out_ready  input  1  consumer accepts head entry
- out_valid  output  1  FIFO non-empty
- out_data  output  CNT_W  head entry (show-ahead)
- level  output  $clog2(DEPTH+1)  entries held, 0..DEPTH
- overflow  output  1  sticky: a capture was dropped because FIFO full

## Operation
- Synchroniser: shift register s[0..SYNC_STAGES-1] clocked by clk; s_prev is a register holding the last s[SYNC_STAGES-1].
- rise = s[SYNC_STAGES-1] & ~s_prev; one clk-cycle pulse per synchronised rising edge; no filtering of short pulses beyond synchroniser sampling.
- push = rise; pushed word = count_in sampled on the same clk edge that writes the FIFO.
- pop = out_valid & out_ready.
- FIFO: circular buffer; wr/rd pointers of $clog2(DEPTH) bits wrap modulo DEPTH; level counter tracks occupancy.
- Full (level==DEPTH):
  - push without pop: word dropped, overflow set to 1, level unchanged.
  - push with pop: both performed, level stays DEPTH, no overflow.
- Empty (level==0): pop impossible (out_valid=0). Push writes entry; no combinational bypass.
- overflow: cleared by clr_ovf. If clr_ovf and a new drop occur in the same cycle, set wins (overflow=1).
- out_data while empty: holds last head RAM value; don't-care for checking.
- Reset (any time, mid-operation included): out_valid=0, out_data=0, level=0, overflow=0, pointers=0, s[]=0, s_prev=0. Queued entries are discarded.
- event_in held high across reset release: produces exactly one capture, since synchroniser restarts at 0.

## Timing
- event_in high and stable before clk edge k: s[0]=1 after edge k; rise asserted during the cycle after edge k+SYNC_STAGES-1; capture written at edge k+SYNC_STAGES.
  - With SYNC_STAGES=2: captured value = count_in present before edge k+2.
- out_valid rises on the edge that writes into an empty FIFO. Push-to-visible latency is 1 cycle.
- Pop takes effect on the clk edge where out_valid & out_ready. The next head appears on out_data after that edge.
- Minimum event spacing for distinct captures: event_in low for ≥1 sampled edge between highs.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- CAPTURE_DELTA_EN defined:
  - Pushed word = count_in − last_capture, modulo 2^CNT_W.
  - last_capture is a CNT_W register; it resets to 0 and updates to count_in on every rise, including dropped pushes.
  - First capture after reset yields the raw count.
- CAPTURE_DELTA_EN undefined: pushed word = raw count_in; last_capture register absent.

## Structure
- Package count_capture_pkg:
  - default constants CNT_W=4, DEPTH=4, SYNC_STAGES=2;
  - function for level width;
  - typedef cnt_t (logic [CNT_W-1:0]).
- Sub-module sync_rise_detect: SYNC_STAGES synchroniser plus s_prev edge detector; outputs rise; async reset to 0.
- FIFO storage, pointers, level, overflow and optional delta logic live in count_capture_fifo.

## Test plan
- Reset then single event: event_in 0→1 at edge 10, held high, count_in = cycle index mod 16, out_ready=0 -> out_valid=1 after edge 12, out_data=12, level=1.
- Burst overflow: 5 events spaced 2 cycles, out_ready=0 -> level=4, overflow=1, the 4 oldest counts retained in order. clr_ovf pulse -> overflow=0.
- Full with simultaneous push/pop: FIFO full, rise coincides with out_ready=1 -> level stays 4, overflow stays 0, new count at tail.
- Wrap-around: 10 events with out_ready=1 continuously -> 10 captures read in order; counts crossing 15→0 read correctly; pointers wrap with no loss.
- Reset mid-operation: level=3, assert reset 1 cycle -> out_valid=0, level=0, overflow=0 immediately; event_in held high across release -> exactly one capture.
- CAPTURE_DELTA_EN: captures at counts 3, 9, 2 -> out_data 3, 6, 9 (modulo 16).

Source files
------------

// File: rtl/count_capture_pkg.sv
// Shared constants and types for the count-capture FIFO slice.
package count_capture_pkg;

  localparam int CNT_W_DEF       = 4;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Width needed to hold an occupancy count of 0..depth inclusive
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/count_capture_fifo_if.sv
// Read-side valid/ready channel of the count-capture FIFO.
interface count_capture_fifo_if
  import count_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/count_capture_fifo_sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous event, followed by a
// one-cycle rising-edge detector on the synchronised level.
module sync_rise_detect
  import count_capture_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic event_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  // Shift the raw event through the synchroniser and remember the last synchronised level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_prev;

endmodule

// File: rtl/count_capture_fifo.sv
// Event timestamp capture: synchronises event_in, samples count_in on each
// rising edge and queues it in a show-ahead FIFO drained over valid/ready.
// Optional feature macro CAPTURE_DELTA_EN: queue the difference from the
// previous capture instead of the raw count.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            count_in,
  input  logic                        event_in,
  input  logic                        clr_ovf,
  count_capture_fifo_if.master        q,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic             rise;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic [CNT_W-1:0] push_word;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem [DEPTH];

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .rise     (rise)
  );

  assign full  = (level == LVL_W'(DEPTH));
  assign pop   = q.out_valid & q.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_en = rise & (~full | pop);
  assign drop  = rise & full & ~pop;

`ifdef CAPTURE_DELTA_EN
  logic [CNT_W-1:0] last_capture;

  // Track the count at every rising edge, including ones whose push is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_capture <= '0;
    else if (rise) last_capture <= count_in;
  end

  assign push_word = count_in - last_capture;
`else
  assign push_word = count_in;
`endif

  // Write the captured word at the tail; contents cleared so out_data reads 0 after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Advance pointers and occupancy on push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign q.out_valid = (level != '0);
  assign q.out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based timestamp model.
module tb_count_capture_fifo;
  import count_capture_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  cnt_t       count_in;
  logic       event_in;
  logic       clr_ovf;
  logic [2:0] level;
  logic       overflow;

  count_capture_fifo_if #(.CNT_W(4)) bus ();

  count_capture_fifo #(
    .CNT_W       (4),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .event_in (event_in),
    .clr_ovf  (clr_ovf),
    .q        (bus),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: a capture lands two edges after event_in is
  // first seen high at an edge, provided it was seen low at the edge before.
  int mq[$];
  bit ovf_m;
  bit h1, h2, h3;
  int last_m;
  int cyc;
  int popped[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic chk_model();
    chk("valid", int'(bus.out_valid), (mq.size() > 0) ? 1 : 0);
    chk("level", int'(level), mq.size());
    chk("overflow", int'(overflow), int'(ovf_m));
    if (mq.size() > 0) chk("data", int'(bus.out_data), mq[0]);
  endtask

  // One clock edge: model consumes the inputs present at the edge
  task automatic step();
    bit cap, pop_m, drop;
    int word;
    if (bus.out_valid && bus.out_ready) popped.push_back(int'(bus.out_data));
    pop_m = (mq.size() > 0) && bus.out_ready;
    cap   = h2 && !h3;
`ifdef CAPTURE_DELTA_EN
    word = (int'(count_in) - last_m) & 15;
`else
    word = int'(count_in);
`endif
    drop = cap && (mq.size() == DEPTH) && !pop_m;
    @(posedge clk);
    if (pop_m) void'(mq.pop_front());
    if (cap && !drop) mq.push_back(word);
    if (cap) last_m = int'(count_in);
    if (drop) ovf_m = 1'b1;
    else if (clr_ovf) ovf_m = 1'b0;
    h3 = h2; h2 = h1; h1 = event_in;
    #1;
    cyc++;
    count_in = cnt_t'(cyc + 1);
    chk_model();
  endtask

  // Async reset: outputs must clear immediately, release one edge later
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_data", int'(bus.out_data), 0);
    mq.delete();
    ovf_m = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; last_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    count_in = cnt_t'(1);
  endtask

  typedef struct {
    bit ev;
    bit rdy;
    bit clr;
    int lvl;
    bit ovf;
    int data;
  } vec_t;

  vec_t tbl[16];
  int   exp_q[$];

  initial begin
    int k;
    // Burst of five events with reader stalled, clear, then drain
    tbl[0]  = '{1, 0, 0, 0, 0, -1};
    tbl[1]  = '{0, 0, 0, 0, 0, -1};
    tbl[2]  = '{1, 0, 0, 1, 0,  3};
    tbl[3]  = '{0, 0, 0, 1, 0,  3};
    tbl[4]  = '{1, 0, 0, 2, 0,  3};
    tbl[5]  = '{0, 0, 0, 2, 0,  3};
    tbl[6]  = '{1, 0, 0, 3, 0,  3};
    tbl[7]  = '{0, 0, 0, 3, 0,  3};
    tbl[8]  = '{1, 0, 0, 4, 0,  3};
    tbl[9]  = '{0, 0, 0, 4, 0,  3};
    tbl[10] = '{0, 0, 0, 4, 1,  3};
    tbl[11] = '{0, 0, 1, 4, 0,  3};
    tbl[12] = '{0, 1, 0, 3, 0,  5};
    tbl[13] = '{0, 1, 0, 2, 0,  7};
    tbl[14] = '{0, 1, 0, 1, 0,  9};
    tbl[15] = '{0, 1, 0, 0, 0, -1};

    event_in = 1'b0; clr_ovf = 1'b0; bus.out_ready = 1'b0;
    count_in = '0; cyc = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single event: high before edge 10, capture of count 12 visible after edge 12
    for (int i = 0; i < 9; i++) step();
    event_in = 1'b1;
    step(); step();
    chk("single_not_yet", int'(bus.out_valid), 0);
    step();
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_data", int'(bus.out_data), 12);
    chk("single_level", int'(level), 1);
    event_in = 1'b0;
    do_reset();

    // Table-driven burst/overflow/clear/drain
    for (int i = 0; i < 16; i++) begin
      event_in = tbl[i].ev; bus.out_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      step();
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_valid", int'(bus.out_valid), (tbl[i].lvl > 0) ? 1 : 0);
      chk("tbl_overflow", int'(overflow), int'(tbl[i].ovf));
`ifndef CAPTURE_DELTA_EN
      if (tbl[i].data >= 0) chk("tbl_data", int'(bus.out_data), tbl[i].data);
`endif
    end
    event_in = 1'b0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    do_reset();

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 5; i++) begin
      event_in = 1'b1; step();
      event_in = 1'b0; step();
    end
    chk("full_level_pre", int'(level), 4);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("full_pp_level", int'(level), 4);
    chk("full_pp_overflow", int'(overflow), 0);
`ifndef CAPTURE_DELTA_EN
    chk("full_pp_head", int'(bus.out_data), 5);
    bus.out_ready = 1'b1;
    step(); step(); step();
    chk("full_pp_tail", int'(bus.out_data), 11);
`endif
    bus.out_ready = 1'b0;
    do_reset();

    // Continuous read, ten captures spanning a counter wrap
    bus.out_ready = 1'b1;
    popped.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      k = cyc + 1;
      exp_q.push_back((k + 2) % 16);
      event_in = 1'b1; step();
      event_in = 1'b0; step();
    end
    for (int i = 0; i < 4; i++) step();
`ifdef CAPTURE_DELTA_EN
    for (int i = 9; i > 0; i--) exp_q[i] = (exp_q[i] - exp_q[i-1]) & 15;
`endif
    chk("wrap_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("wrap_word", popped[i], exp_q[i]);
    bus.out_ready = 1'b0;
    do_reset();

    // Reset mid-operation with event held high across release
    for (int i = 0; i < 3; i++) begin
      event_in = 1'b1; step();
      event_in = 1'b0; step();
    end
    step();
    chk("mid_level_pre", int'(level), 3);
    event_in = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("mid_one_capture", int'(level), 1);
    event_in = 1'b0;
    step();

`ifdef CAPTURE_DELTA_EN
    // Captures at counts 3, 9, 2 queue deltas 3, 6, 9
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      event_in = (e == 1 || e == 7 || e == 16);
      step();
    end
    event_in = 1'b0;
    chk("delta_level", int'(level), 3);
    chk("delta_first", int'(bus.out_data), 3);
    bus.out_ready = 1'b1;
    step();
    chk("delta_second", int'(bus.out_data), 6);
    step();
    chk("delta_third", int'(bus.out_data), 9);
    bus.out_ready = 1'b0;
`endif

    // Randomized traffic: stalled reader first, then a mostly ready one
    do_reset();
    for (int i = 0; i < 400; i++) begin
      event_in      = ($urandom_range(0, 2) == 0);
      bus.out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf       = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_total);
    $fatal(1);
  end

endmodule
